alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 4-bit `alu_control` code produced by the ALU control decoder, together with two operands, and returns a registered result with zero and illegal-op flags. Single-cycle operations complete one cycle after acceptance. Code `4'b1111` (the `alu_op == 2'b11` path) runs an iterative shift-add multiply. Valid/ready handshakes sit on both sides so the pipeline can stall around the multi-cycle case.

---
 rtl/alu_exec_unit.sv | 162 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshakes and iterative multiply
//
// Purpose:
//   Accepts an operation code plus two operands, produces a registered result
//   with zero/illegal flags. Logic ops, add/sub, SLT and complement finish one
//   cycle after acceptance; code 4'b1111 runs a WIDTH-cycle shift-add multiply.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   in_valid / in_ready   - request handshake (alu_control, op_a, op_b)
//   out_valid / out_ready - result handshake (result, zero, illegal)
//   result                - WIDTH-bit operation result
//   zero                  - result == 0, valid while out_valid
//   illegal               - accepted code was unsupported, valid while out_valid

module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_OR  = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  logic             accept;
  logic             is_mul;
  logic             last_iter;
  logic [WIDTH-1:0] op_res;
  logic             op_illegal;
  logic [WIDTH-1:0] acc_step;

  assign accept    = in_valid && in_ready;
  assign is_mul    = (alu_control == OP_MUL);
  assign last_iter = (count == CW'(WIDTH - 1));
  assign out_valid = (state == DONE);

  // Accumulator value after the current shift-add iteration.
  assign acc_step  = mplier[0] ? (acc + mcand) : acc;

  // Single-cycle datapath; unsupported codes yield result 0 with illegal set.
  always_comb begin
    op_res     = '0;
    op_illegal = 1'b0;
    case (alu_control)
      OP_OR:   op_res = op_a | op_b;
      OP_AND:  op_res = op_a & op_b;
      OP_ADD:  op_res = op_a + op_b;
      OP_XOR:  op_res = op_a ^ op_b;
      OP_SUB:  op_res = op_a - op_b;
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_NOT:  op_res = ~op_a;
      OP_MUL:  op_res = '0;
      default: op_illegal = 1'b1;
    endcase
  end

  // Next-state and request-side ready. In DONE a new request can only enter
  // in the same cycle the held result is consumed.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = is_mul ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_next = is_mul ? BUSY : DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (is_mul) begin
          mcand  <= op_a;
          mplier <= op_b;
          acc    <= '0;
          count  <= '0;
        end else begin
          result  <= op_res;
          zero    <= (op_res == '0);
          illegal <= op_illegal;
        end
      end else if (state == BUSY) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        // The final iteration writes the product straight into the output
        // registers so DONE is entered on the same edge.
        if (last_iter) begin
          result  <= acc_step;
          zero    <= (acc_step == '0);
          illegal <= 1'b0;
          count   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [33:0] sb[$];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        il;
    logic [63:0] p;
    r  = 32'd0;
    il = 1'b0;
    p  = 64'd0;
    case (c)
      4'b0000: r = a | b;
      4'b0001: r = a & b;
      4'b0010: r = a + b;
      4'b0100: r = a ^ b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: r = ~a;
      4'b1111: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      default: il = 1'b1;
    endcase
    return {r, (r == 32'd0), il};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it until accepted; returns cycles waited.
  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int waits);
    logic ok;
    in_valid    = 1'b1;
    alu_control = c;
    op_a        = a;
    op_b        = b;
    waits       = 0;
    ok          = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (!ok) begin
        waits++;
        if (waits > 200) begin
          check("accept_timeout", 0, 1);
          break;
        end
      end
    end
    if (ok) sb.push_back(model(c, a, b));
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    alu_control = 4'b0000;
    op_a        = 32'd0;
    op_b        = 32'd0;
  endtask

  // Scoreboard: every completed output transfer is matched in order.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {1'b1, result}, 0);
      end else begin
        check("result_zero_illegal", {30'd0, result, zero, illegal}, {30'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cyc;
    logic bad_ready;
    logic [3:0] codes [8];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110, 4'b0111, 4'b1000, 4'b1111};

    reset = 1'b1;
    out_ready = 1'b1;
    idle();
    step(); step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    reset = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);

    // ADD wrap to zero, out_valid for exactly one cycle
    drive(4'b0010, 32'hFFFF_FFFF, 32'd1, w);
    idle();
    check("add_wait", w, 0);
    check("add_out_valid", out_valid, 1);
    check("add_zero", zero, 1);
    step();
    check("add_one_cycle", out_valid, 0);

    // back-to-back SUB, SLT, NOT with no bubbles
    drive(4'b0110, 32'd5, 32'd7, w);
    drive(4'b0111, 32'hFFFF_FFFE, 32'd1, w);
    check("b2b_slt_wait", w, 0);
    check("b2b_valid1", out_valid, 1);
    drive(4'b1000, 32'h0000_FFFF, 32'd0, w);
    check("b2b_not_wait", w, 0);
    check("b2b_valid2", out_valid, 1);
    idle();
    check("b2b_not_result", result, 32'hFFFF_0000);
    step();
    check("b2b_drain", out_valid, 0);

    // MUL latency and in_ready low while iterating
    drive(4'b1111, 32'h0001_2345, 32'h0000_0100, w);
    idle();
    cyc = 0;
    bad_ready = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) bad_ready = 1'b1;
      step();
      cyc++;
    end
    check("mul_latency", cyc, 32);
    check("mul_busy_ready", bad_ready, 0);
    check("mul_result", result, 32'h0123_4500);
    step();
    drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
    idle();
    cyc = 0;
    while (!out_valid && cyc < 100) begin step(); cyc++; end
    check("mul_ff_result", result, 32'd1);
    step();

    // unsupported code
    drive(4'b0011, 32'd7, 32'd9, w);
    idle();
    check("ill_out_valid", out_valid, 1);
    check("ill_flag", illegal, 1);
    step();

    // backpressure: result held, in_ready low
    out_ready = 1'b0;
    drive(4'b0000, 32'h0000_00F0, 32'h0000_000F, w);
    idle();
    for (int i = 0; i < 5; i++) begin
      check("bp_result", result, 32'hFF);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    check("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    check("bp_release", out_valid, 0);

    // reset in the middle of a multiply
    drive(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, w);
    idle();
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_result", result, 0);
    drive(4'b0010, 32'd2, 32'd3, w);
    idle();
    check("post_rst_add", result, 32'd5);
    step();

    // randomized ops over the supported set
    for (int i = 0; i < 10; i++) begin
      drive(codes[$urandom_range(7)], $urandom, $urandom, w);
      idle();
      cyc = 0;
      while (!out_valid && cyc < 100) begin step(); cyc++; end
      check("rand_done", out_valid, 1);
      step();
    end

    step(); step();
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
